// File: rtl/sram_ctrl_pkg.sv
// Shared constants and helpers for the 1RW+1R SRAM request/response controller.
package sram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_NUM_BYTES  = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8 * DEF_NUM_BYTES;
    localparam int unsigned RESP_DEPTH     = 2;
    localparam int unsigned OCC_WIDTH      = $clog2(RESP_DEPTH + 1);

    function automatic int unsigned data_width_of(input int unsigned num_bytes);
        return 8 * num_bytes;
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 1 << addr_width;
    endfunction

    // A new read may be issued only while at most one result is owed to the consumer.
    function automatic logic can_accept(input logic [OCC_WIDTH-1:0] occ, input logic inflight);
        return (occ + OCC_WIDTH'(inflight)) <= OCC_WIDTH'(RESP_DEPTH - 1);
    endfunction

endpackage

// File: rtl/sram_rd_buf.sv
// Per-port read pipe: in-flight flag, 2-entry response FIFO with bypass, request ready.
module sram_rd_buf
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata
);

    logic                  rst_n_q;
    logic                  inflight;
    logic                  head;
    logic                  tail;
    logic [OCC_WIDTH-1:0]  occ;
    logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign empty = (occ == '0);
    // Macro data is captured unless it was bypassed straight to a ready consumer.
    assign push  = inflight & ~(empty & resp_ready);
    assign pop   = ~empty & resp_ready;

    assign req_ready  = rst_n_q & can_accept(occ, inflight);
    assign resp_valid = inflight | ~empty;
    assign resp_rdata = empty ? dout : mem[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q  <= 1'b0;
            inflight <= 1'b0;
            occ      <= '0;
            head     <= 1'b0;
            tail     <= 1'b0;
        end else begin
            rst_n_q  <= 1'b1;
            inflight <= issue;
            occ      <= occ + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= dout;
        end
    end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// Valid/ready front end for a bank of byte-wide 1RW+1R macros: pin mapping and write/read collision guard.
module sram_1rw1r_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_BYTES  = DEF_NUM_BYTES,
    localparam int unsigned DATA_WIDTH = data_width_of(NUM_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [NUM_BYTES-1:0]  p0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_resp_valid,
    input  logic                  p0_resp_ready,
    output logic [DATA_WIDTH-1:0] p0_resp_rdata,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    output logic                  p1_resp_valid,
    input  logic                  p1_resp_ready,
    output logic [DATA_WIDTH-1:0] p1_resp_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_BYTES-1:0]  sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,

    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic p0_fire;
    logic p0_rd_issue;
    logic p1_fire;
    logic p1_buf_ready;
    logic collide;

    assign p0_fire     = p0_req_valid & p0_req_ready;
    assign p0_rd_issue = p0_fire & ~p0_req_we;

    // Port 0 wins a same-address write/read race; port 1 retries and sees the new data.
    assign collide      = p0_fire & p0_req_we & (p0_req_addr == p1_req_addr);
    assign p1_req_ready = p1_buf_ready & ~collide;
    assign p1_fire      = p1_req_valid & p1_req_ready;

    assign sram_csb0   = ~p0_fire;
    assign sram_web0   = ~(p0_fire & p0_req_we);
    assign sram_wmask0 = !p0_fire ? '0 : (p0_req_we ? p0_req_wmask : '1);
    assign sram_addr0  = p0_req_addr;
    assign sram_din0   = p0_req_wdata;

    assign sram_csb1  = ~p1_fire;
    assign sram_addr1 = p1_req_addr;

    sram_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_p0_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (p0_rd_issue),
        .dout       (sram_dout0),
        .req_ready  (p0_req_ready),
        .resp_valid (p0_resp_valid),
        .resp_ready (p0_resp_ready),
        .resp_rdata (p0_resp_rdata)
    );

    sram_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_p1_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (p1_fire),
        .dout       (sram_dout1),
        .req_ready  (p1_buf_ready),
        .resp_valid (p1_resp_valid),
        .resp_ready (p1_resp_ready),
        .resp_rdata (p1_resp_rdata)
    );

endmodule

// File: doc/sram_1rw1r_ctrl.md
# sram_1rw1r_ctrl

Request/response controller that drives a bank of NUM_BYTES byte-wide 1RW+1R OpenRAM macros (8x1024 each, control pins shared, wmask bit i to macro i) as one NUM_BYTES*8-bit memory. It sits between core-side valid/ready clients and the macro pins. It:
- converts the macro's unflow-controlled one-cycle read into backpressurable responses;
- resolves same-address write/read collisions between the two ports.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width (macro depth 1<<ADDR_WIDTH)
- NUM_BYTES, 4, number of byte-wide macros; DATA_WIDTH = 8*NUM_BYTES

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  single clock, also drives macro clk0/clk1
  - rst_n  in  1  synchronous active-low reset
- Port 0 request (read/write):
  - p0_req_valid  in  1  port-0 request
  - p0_req_ready  out  1  port-0 request accepted when valid&ready
  - p0_req_we  in  1  1 = write, 0 = read
  - p0_req_wmask  in  NUM_BYTES  byte write enables (ignored on read)
  - p0_req_addr  in  ADDR_WIDTH  word address
  - p0_req_wdata  in  DATA_WIDTH  write data
- Port 0 response:
  - p0_resp_valid  out  1  read data valid
  - p0_resp_ready  in  1  consumer accepts read data
  - p0_resp_rdata  out  DATA_WIDTH  read data
- Port 1 (read-only) request and response:
  - p1_req_valid / p1_req_ready  in / out  1  port-1 read request handshake
  - p1_req_addr  in  ADDR_WIDTH  port-1 address
  - p1_resp_valid / p1_resp_ready  out / in  1  port-1 response handshake
  - p1_resp_rdata  out  DATA_WIDTH  port-1 read data
- Macro side, port 0:
  - sram_csb0, sram_web0  out  1  macro port-0 chip select / write enable (active low)
  - sram_wmask0  out  NUM_BYTES  per-macro write mask
  - sram_addr0  out  ADDR_WIDTH
  - sram_din0  out  DATA_WIDTH
  - sram_dout0  in  DATA_WIDTH  concatenated macro dout0
- Macro side, port 1:
  - sram_csb1  out  1  macro port-1 chip select (active low)
  - sram_addr1  out  ADDR_WIDTH
  - sram_dout1  in  DATA_WIDTH  concatenated macro dout1

## Operation
- Each port is an independent pipe: accept stage, one-cycle in-flight flag, 2-entry response buffer with bypass.
- Macro pins are combinational from the accepted request.
  - sram_csb0 = !(p0_req_valid & p0_req_ready); sram_web0 = !p0_req_we.
  - sram_wmask0 = p0_req_wmask on writes, all-ones on reads.
  - addr/din pass through.
  - csb held high whenever no request is accepted, including during reset.
- Writes produce no response. A write with wmask = 0 is accepted, asserts csb0 and changes nothing.
- Read accepted at edge N sets the port's inflight flag. At cycle N+1, sram_doutX is valid.
  - If the buffer is empty, resp_rdata = sram_doutX (bypass) and resp_valid = 1.
  - If not handshaken that cycle, the data is written into the buffer at edge N+1.
- Buffer is a 2-entry FIFO; responses leave strictly in request order per port.
- Flow control: req_ready = rst_n_q & (occ + inflight <= 1), registered terms only. There is no combinational path from resp_ready to req_ready.
  - Guarantees no dout is lost.
  - Sustains one read per cycle when resp_ready stays high.
- Collision rule: p1_req_ready is forced 0 in any cycle where a p0 write is being accepted to the same address as p1_req_addr. Port 0 has priority; the p1 read issues next cycle and returns the new data.
- Different-address concurrent p0 write and p1 read, and same-address concurrent reads, proceed in parallel.
- Reset (rst_n = 0 at an edge):
  - occ = 0, inflight = 0.
  - resp_valid = 0, req_ready = 0, csb0 = csb1 = web0 = 1, wmask0 = 0.
  - In-flight reads are discarded.
  - req_ready rises on the first cycle after rst_n is sampled high (rst_n_q).

## Timing
- Read latency: 1 cycle (accept edge N -> resp_valid during cycle N+1) when the buffer is empty; otherwise behind queued entries.
- Write is visible to a read accepted at the next edge on either port.
- Once resp_valid is asserted it stays high with rdata stable until resp_ready.
- Maximum stall recovery: after resp_ready returns, req_ready reasserts within 1 cycle once occ+inflight <= 1.
- Outputs after reset:
  - req_ready = 0 until the first cycle after rst_n is sampled high.
  - resp_valid = 0.
  - rdata = don't-care, with resp_valid low.

## Structure
- Shared package sram_ctrl_pkg: DEPTH/width localparams derived from ADDR_WIDTH, NUM_BYTES; constant RESP_DEPTH = 2.
- One sub-module, sram_rd_buf: per-port inflight flag, 2-entry FIFO with bypass, ready computation. It is instantiated twice (p0, p1).
- Top contains only macro pin mapping and the collision comparator.
- The macros are instantiated by the parent, not inside this block.

## Test plan
- Write addr 0x005 data 0xA1B2C3D4 mask 0xF, then p0 read 0x005 with resp_ready = 1 -> resp_valid one cycle after accept, rdata 0xA1B2C3D4.
- Write 0x005 mask 0x2 data 0x0000EE00 -> subsequent read returns 0xA1B2EED4.
- Same-cycle p0 write 0x010 = 0x11111111 and p1 read 0x010 -> p1_req_ready = 0 that cycle; p1 read issues next cycle and returns 0x11111111.
- p1 back-to-back reads 0x000..0x007 with p1_resp_ready held 0 -> exactly 2 accepted, ready drops. Raise resp_ready -> all 8 data returned in order, none lost.
- Streaming p0 reads with resp_ready = 1 for 16 cycles -> 16 accepts, 16 responses, throughput 1/cycle.
- Assert rst_n = 0 with a read in flight and the buffer full -> next cycle resp_valid = 0 and csb0/csb1 = 1; no stale response after reset.
